// File: rtl/lz77_copy_dec.sv
// LZ77 decode-side copy engine: rebuilds the byte stream from literal and
// (length, distance) tokens using a WIN_DEP-byte history. Optional token checking: LZ77_COPY_DEC_CHK_EN.
module lz77_copy_dec #(
  parameter int WIN_DEP = 64,
  parameter int WIN_WD  = $clog2(WIN_DEP),
  parameter int DIS_WD  = WIN_WD + 1,
  parameter int LEN_WD  = 9
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              tok_val_i,
  output logic              tok_rdy_o,
  input  logic              tok_typ_i,
  input  logic [7:0]        tok_lit_i,
  input  logic [LEN_WD-1:0] tok_len_i,
  input  logic [DIS_WD-1:0] tok_dis_i,
  output logic              dat_val_o,
  input  logic              dat_rdy_i,
  output logic [7:0]        dat_o,
  output logic              err_o
);

  typedef enum logic {IDLE = 1'b0, COPY = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [WIN_WD-1:0]   wp_q, wp_d;
  logic [DIS_WD-1:0]   fill_q, fill_d;
  logic [LEN_WD-1:0]   len_q, len_d;
  logic [DIS_WD-1:0]   dis_q, dis_d;
  logic                dat_val_q, dat_val_d;
  logic [7:0]          dat_q, dat_d;
  logic                err_q, err_d;

  logic [7:0]          hist [WIN_DEP];
  logic [WIN_WD-1:0]   rd_addr_s;
  logic                slot_free_s;
  logic                tok_rdy_s;
  logic                gen_s;
  logic [7:0]          gen_byte_s;
  logic                illegal_s;

  // Distance WIN_DEP wraps to the current write slot, i.e. the oldest byte.
  assign rd_addr_s   = wp_q - WIN_WD'(dis_q);
  assign slot_free_s = !dat_val_q || dat_rdy_i;

`ifdef LZ77_COPY_DEC_CHK_EN
  assign illegal_s = (tok_dis_i == {DIS_WD{1'b0}}) ||
                     (tok_dis_i > DIS_WD'(WIN_DEP)) ||
                     (tok_dis_i > fill_q) ||
                     (tok_len_i < LEN_WD'(3)) ||
                     (tok_len_i > LEN_WD'(258));
`else
  assign illegal_s = 1'b0;
`endif

  // Next-state, byte generation and history bookkeeping.
  always_comb begin
    state_d    = state_q;
    wp_d       = wp_q;
    fill_d     = fill_q;
    len_d      = len_q;
    dis_d      = dis_q;
    dat_d      = dat_q;
    err_d      = err_q;
    gen_s      = 1'b0;
    gen_byte_s = 8'h00;
    tok_rdy_s  = 1'b0;

    if (dat_val_q && dat_rdy_i) begin
      dat_val_d = 1'b0;
    end else begin
      dat_val_d = dat_val_q;
    end

    case (state_q)
      IDLE: begin
        tok_rdy_s = slot_free_s;
        if (tok_val_i && slot_free_s) begin
          if (!tok_typ_i) begin
            gen_s      = 1'b1;
            gen_byte_s = tok_lit_i;
          end else if (illegal_s) begin
            err_d = 1'b1;
          end else begin
            len_d   = tok_len_i;
            dis_d   = tok_dis_i;
            state_d = COPY;
          end
        end else begin
          state_d = IDLE;
        end
      end
      COPY: begin
        if (slot_free_s) begin
          gen_s      = 1'b1;
          gen_byte_s = hist[rd_addr_s];
          len_d      = len_q - LEN_WD'(1);
          if (len_q == LEN_WD'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = COPY;
          end
        end else begin
          state_d = COPY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (gen_s) begin
      dat_d     = gen_byte_s;
      dat_val_d = 1'b1;
      wp_d      = wp_q + WIN_WD'(1);
      if (fill_q == DIS_WD'(WIN_DEP)) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + DIS_WD'(1);
      end
    end else begin
      wp_d = wp_q;
    end
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      wp_q      <= {WIN_WD{1'b0}};
      fill_q    <= {DIS_WD{1'b0}};
      len_q     <= {LEN_WD{1'b0}};
      dis_q     <= {DIS_WD{1'b0}};
      dat_val_q <= 1'b0;
      dat_q     <= 8'h00;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      fill_q    <= fill_d;
      len_q     <= len_d;
      dis_q     <= dis_d;
      dat_val_q <= dat_val_d;
      dat_q     <= dat_d;
      err_q     <= err_d;
    end
  end

  // History RAM: written with every generated byte, contents not reset.
  always_ff @(posedge clk) begin
    if (rstn && gen_s) begin
      hist[wp_q] <= gen_byte_s;
    end
  end

  assign tok_rdy_o = rstn && tok_rdy_s;
  assign dat_val_o = dat_val_q;
  assign dat_o     = dat_q;
  assign err_o     = err_q;

endmodule
